// File: rtl/thread_dispatch_pkg.sv
// Shared constants for the per-core packet-work dispatcher: thread count,
// giveup FSM state encodings and the default pending-counter width.
package thread_dispatch_pkg;

   localparam int NUM_THREADS   = 4;
   localparam int CNT_W_DEFAULT = 4;

   localparam logic [1:0] G_IDLE   = 2'b00;
   localparam logic [1:0] G_ASSERT = 2'b01;
   localparam logic [1:0] G_WAIT   = 2'b10;

endpackage

// File: rtl/thread_pend_cnt.sv
// One saturating up/down pending-descriptor counter with sticky overflow
// (enq while full) and underflow (done while empty) flags.
module thread_pend_cnt
   import thread_dispatch_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             dec_i,
   input  logic             err_clr_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o,
   output logic             udf_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             ovf_evt, udf_evt;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d   = cnt_q;
      ovf_evt = 1'b0;
      udf_evt = 1'b0;
      if (inc_i && !dec_i) begin
         if (cnt_q == CNT_MAX) ovf_evt = 1'b1;
         else                  cnt_d   = cnt_q + 1'b1;
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0) udf_evt = 1'b1;
         else             cnt_d   = cnt_q - 1'b1;
      end
      // A fresh error in the clear cycle keeps the flag set.
      ovf_d = (ovf_q & ~err_clr_i) | ovf_evt;
      udf_d = (udf_q & ~err_clr_i) | udf_evt;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;
   assign udf_o = udf_q;

endmodule

// File: rtl/thread_dispatch.sv
// Per-core dispatcher: per-thread pending counters, scheduler request vector
// and the giveup FSM. Optional run watchdog under THREAD_DISPATCH_WDOG_EN.
module thread_dispatch
   import thread_dispatch_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEFAULT,
   parameter int WDOG_CYCLES = 2048
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_THREADS-1:0]         enq,
   input  logic [NUM_THREADS-1:0]         thread_en,
   input  logic [1:0]                     thread_id,
   input  logic                           thread_running,
   input  logic                           thread_done,
   input  logic                           err_clr,
   output logic [NUM_THREADS-1:0]         pq_req,
   output logic                           thread_giveup,
   output logic [NUM_THREADS*CNT_W-1:0]   pend_cnt,
   output logic [NUM_THREADS-1:0]         ovf,
   output logic [NUM_THREADS-1:0]         udf,
   output logic [NUM_THREADS-1:0]         wdog_hit
);

   logic [CNT_W-1:0] cnt [NUM_THREADS];
   logic             wdog_fire;
   logic [1:0]       state_q, state_d;
   logic             sel_idle_cond;

   for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thread
      thread_pend_cnt #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk       (clk),
         .reset     (reset),
         .inc_i     (enq[i]),
         .dec_i     (thread_done && (thread_id == 2'(i))),
         .err_clr_i (err_clr),
         .cnt_o     (cnt[i]),
         .ovf_o     (ovf[i]),
         .udf_o     (udf[i])
      );
      assign pend_cnt[i*CNT_W +: CNT_W] = cnt[i];
      assign pq_req[i] = (cnt[i] != '0) & thread_en[i];
   end

`ifdef THREAD_DISPATCH_WDOG_EN
   localparam int              WDOG_W    = 11;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

   logic [WDOG_W-1:0]      run_cnt_q, run_cnt_d;
   logic [1:0]             last_id_q;
   logic [NUM_THREADS-1:0] wdog_hit_q, wdog_hit_d;
   logic                   run_clr;

   // A run is a stretch of running cycles on one thread with no completed packet.
   assign run_clr   = !thread_running || thread_done || (thread_id != last_id_q);
   assign wdog_fire = !run_clr && (run_cnt_q == WDOG_LAST);

   always_comb begin
      run_cnt_d  = (run_clr || wdog_fire) ? '0 : run_cnt_q + 1'b1;
      wdog_hit_d = wdog_hit_q & {NUM_THREADS{~err_clr}};
      if (wdog_fire) wdog_hit_d[thread_id] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run_cnt_q  <= '0;
         last_id_q  <= 2'b00;
         wdog_hit_q <= '0;
      end else begin
         run_cnt_q  <= run_cnt_d;
         last_id_q  <= thread_id;
         wdog_hit_q <= wdog_hit_d;
      end
   end

   assign wdog_hit = wdog_hit_q;
`else
   localparam int WDOG_CYCLES_UNUSED = WDOG_CYCLES;

   assign wdog_fire = 1'b0;
   assign wdog_hit  = '0;
`endif

   assign sel_idle_cond = (cnt[thread_id] == '0) || !thread_en[thread_id] || wdog_fire;

   // One giveup per context switch: wait for the scheduler to stop, then restart.
   always_comb begin
      state_d = state_q;
      case (state_q)
         G_IDLE:   if (thread_running && sel_idle_cond) state_d = G_ASSERT;
         G_ASSERT: if (!thread_running)                 state_d = G_WAIT;
         G_WAIT:   if (thread_running)                  state_d = G_IDLE;
         default:                                       state_d = G_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= G_IDLE;
      else       state_q <= state_d;
   end

   assign thread_giveup = (state_q == G_ASSERT);

endmodule

// File: tb/tb_thread_dispatch.sv
// Self-checking bench for thread_dispatch: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_thread_dispatch;

   localparam int CNT_W       = 4;
   localparam int WDOG_CYCLES = 16;
   localparam int NT          = 4;
   localparam int CMAX        = (1 << CNT_W) - 1;
`ifdef THREAD_DISPATCH_WDOG_EN
   localparam bit WDOG_ON = 1'b1;
`else
   localparam bit WDOG_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [NT-1:0]     enq;
   logic [NT-1:0]     thread_en;
   logic [1:0]        thread_id;
   logic              thread_running;
   logic              thread_done;
   logic              err_clr;
   logic [NT-1:0]     pq_req;
   logic              thread_giveup;
   logic [NT*CNT_W-1:0] pend_cnt;
   logic [NT-1:0]     ovf;
   logic [NT-1:0]     udf;
   logic [NT-1:0]     wdog_hit;

   always #5 clk = ~clk;

   thread_dispatch #(
      .CNT_W       (CNT_W),
      .WDOG_CYCLES (WDOG_CYCLES)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .enq            (enq),
      .thread_en      (thread_en),
      .thread_id      (thread_id),
      .thread_running (thread_running),
      .thread_done    (thread_done),
      .err_clr        (err_clr),
      .pq_req         (pq_req),
      .thread_giveup  (thread_giveup),
      .pend_cnt       (pend_cnt),
      .ovf            (ovf),
      .udf            (udf),
      .wdog_hit       (wdog_hit)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: pending counts, sticky flags, switch-in-flight phase.
   int          m_cnt [NT];
   bit [NT-1:0] m_ovf, m_udf, m_hit;
   bit          m_assert, m_wait;
   int          m_run, m_last_id;

   always @(posedge clk) begin
      bit          fire;
      int          id;
      bit          inc, dec;
      logic [NT-1:0] exp_pq;
      id   = int'(thread_id);
      fire = 1'b0;
      if (reset) begin
         for (int i = 0; i < NT; i++) m_cnt[i] = 0;
         m_ovf = '0; m_udf = '0; m_hit = '0;
         m_assert = 1'b0; m_wait = 1'b0;
         m_run = 0; m_last_id = 0;
      end else begin
         if (WDOG_ON) begin
            if (!thread_running || thread_done || id != m_last_id) m_run = 0;
            else if (m_run == WDOG_CYCLES - 1) begin fire = 1'b1; m_run = 0; end
            else m_run++;
         end
         m_last_id = id;
         if (m_assert) begin
            if (!thread_running) begin m_assert = 1'b0; m_wait = 1'b1; end
         end else if (m_wait) begin
            if (thread_running) m_wait = 1'b0;
         end else if (thread_running && (m_cnt[id] == 0 || !thread_en[id] || fire)) begin
            m_assert = 1'b1;
         end
         if (err_clr) begin m_ovf = '0; m_udf = '0; m_hit = '0; end
         if (fire) m_hit[id] = 1'b1;
         for (int i = 0; i < NT; i++) begin
            inc = enq[i];
            dec = thread_done && (id == i);
            if (inc && !dec) begin
               if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
               else m_cnt[i]++;
            end else if (dec && !inc) begin
               if (m_cnt[i] == 0) m_udf[i] = 1'b1;
               else m_cnt[i]--;
            end
         end
      end
      #1;
      for (int i = 0; i < NT; i++) begin
         check($sformatf("model_cnt%0d", i), pend_cnt[i*CNT_W +: CNT_W], m_cnt[i]);
         exp_pq[i] = (m_cnt[i] != 0) && thread_en[i];
      end
      check("model_pq_req", pq_req, exp_pq);
      check("model_giveup", thread_giveup, m_assert);
      check("model_ovf", ovf, m_ovf);
      check("model_udf", udf, m_udf);
      check("model_wdog_hit", wdog_hit, m_hit);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_enq(input logic [NT-1:0] m);
      enq = m;
      tick();
      enq = '0;
   endtask

   task automatic pulse_done();
      thread_done = 1'b1;
      tick();
      thread_done = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enq = '0; thread_en = 4'hF; thread_id = 2'd0;
      thread_running = 1'b0; thread_done = 1'b0; err_clr = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check("reset_pq_req", pq_req, 4'b0000);
      check("reset_giveup", thread_giveup, 1'b0);
      check("reset_pend_cnt", pend_cnt, 16'h0000);

      // Three descriptors for thread 2.
      pulse_enq(4'b0100);
      check("pq_after_first_enq2", pq_req, 4'b0100);
      pulse_enq(4'b0100);
      pulse_enq(4'b0100);
      check("cnt2_after_three_enq", pend_cnt[11:8], 3);
      thread_en = 4'b1011;
      #1;
      check("pq_masked_same_cycle", pq_req, 4'b0000);
      thread_en = 4'hF;

      // Thread 1 drains its last packet and gives up two cycles later.
      pulse_enq(4'b0010);
      thread_id = 2'd1; thread_running = 1'b1;
      tick(); tick();
      check("giveup_idle_busy", thread_giveup, 1'b0);
      pulse_done();
      check("cnt1_after_done", pend_cnt[7:4], 0);
      check("giveup_not_yet", thread_giveup, 1'b0);
      tick();
      check("giveup_after_done", thread_giveup, 1'b1);
      tick();
      check("giveup_held", thread_giveup, 1'b1);
      thread_running = 1'b0;
      tick();
      check("giveup_drops", thread_giveup, 1'b0);
      tick(); tick();
      check("giveup_no_retrigger", thread_giveup, 1'b0);
      thread_running = 1'b1;
      tick();
      check("giveup_restart", thread_giveup, 1'b0);
      thread_running = 1'b0;
      tick();

      // Simultaneous enq and done on thread 0.
      pulse_enq(4'b0001);
      pulse_enq(4'b0001);
      thread_id = 2'd0; thread_running = 1'b1;
      enq = 4'b0001; thread_done = 1'b1;
      tick();
      enq = '0; thread_done = 1'b0;
      check("cnt0_enq_and_done", pend_cnt[3:0], 2);
      tick();
      check("giveup_cnt0_busy", thread_giveup, 1'b0);
      thread_running = 1'b0;
      tick();

      // Saturation of thread 3.
      repeat (16) pulse_enq(4'b1000);
      check("cnt3_saturated", pend_cnt[15:12], 15);
      check("ovf3_set", ovf, 4'b1000);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("ovf_cleared", ovf, 4'b0000);

      // Underflow on thread 2.
      thread_id = 2'd2;
      repeat (3) pulse_done();
      check("cnt2_drained", pend_cnt[11:8], 0);
      check("udf_clear_before", udf, 4'b0000);
      pulse_done();
      check("udf2_set", udf, 4'b0100);
      check("cnt2_holds_zero", pend_cnt[11:8], 0);

      // Long run on thread 0 with pending work: only the watchdog can preempt.
      thread_id = 2'd0;
      tick();
      thread_running = 1'b1;
      repeat (20) tick();
      check("wdog_giveup", thread_giveup, WDOG_ON ? 1'b1 : 1'b0);
      check("wdog_hit0", wdog_hit, WDOG_ON ? 4'b0001 : 4'b0000);
      thread_running = 1'b0;
      tick(); tick();

      // Reset while a giveup is in flight.
      thread_id = 2'd1; thread_running = 1'b1;
      tick(); tick();
      check("giveup_before_reset", thread_giveup, 1'b1);
      reset = 1'b1; thread_running = 1'b0;
      tick();
      reset = 1'b0;
      check("reset_mid_switch_giveup", thread_giveup, 1'b0);
      check("reset_mid_switch_cnt", pend_cnt, 16'h0000);
      check("reset_mid_switch_udf", udf, 4'b0000);

      // Randomized traffic; the model process checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         enq            = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         thread_done    = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) thread_id = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) thread_running = ~thread_running;
         thread_en      = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         err_clr        = ($urandom_range(0, 49) == 0);
         reset          = ($urandom_range(0, 499) == 0);
         tick();
      end
      reset = 1'b0; enq = '0; thread_done = 1'b0; err_clr = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
